vector_mac_pe: RTL and testbench
================================

Name: vector_mac_pe

Overview:
Multi-lane, pipelined multiply-accumulate processing element. It replaces the single-lane accumulating PE in the systolic datapath. LANES independent MACs share one valid/ready input stream and one valid/ready result stream. It adds signed/unsigned operand modes, optional saturation, per-lane overflow flags and explicit vector framing via in_last.

Parameters:
PRECISION, 8, operand width per lane (bits)
OUTPUT_PRECISION, 32, accumulator/result width per lane; must be >= 2*PRECISION+1
LANES, 4, number of parallel MAC lanes

Ports:
CLK  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high
in_valid  input  1  input beat valid
in_ready  output  1  PE can accept a beat
in_last  input  1  final beat of current vector
signed_mode  input  1  1 = operands two's complement, 0 = unsigned; sampled per beat
sat_en  input  1  1 = saturate accumulator, 0 = wrap; sampled per beat
a_in  input  LANES*PRECISION  lane i operand A in bits [i*PRECISION +: PRECISION]
b_in  input  LANES*PRECISION  lane i operand B, same packing
out_valid  output  1  result vector valid
out_ready  input  1  consumer accepts result
s_out  output  LANES*OUTPUT_PRECISION  per-lane accumulated result, same packing
overflow  output  LANES  sticky per-lane overflow for the current vector

Behaviour:
- Reset (reset=1 at an edge): state=ACCUM; all accumulators, product registers, stage-1 valid, s_out, overflow and out_valid go to 0. in_ready is forced to 0 while reset is high. Reset mid-vector or mid-OUT discards all in-flight data. No partial result is emitted.
- States:
  - ACCUM: in_ready=1.
  - FLUSH: in_ready=0; waits for the last product to retire.
  - OUT: in_ready=0, out_valid=1.
- Accept: beat is taken when in_valid && in_ready at an edge. Bubbles (in_valid=0) are allowed anywhere in a vector.
- Stage 1 (accept edge k): each lane registers the product a*b at 2*PRECISION bits. signed_mode/sat_en are registered alongside the product.
- Stage 2 (edge k+1): the product is sign- or zero-extended to OUTPUT_PRECISION and added to the lane accumulator.
- Transitions:
  - ACCUM -> FLUSH on accepting a beat with in_last=1.
  - FLUSH -> OUT on the next edge, when that product is accumulated.
  - OUT -> ACCUM on out_valid && out_ready. On that edge all accumulators and overflow flags clear.
- Latency: last beat accepted at edge k -> out_valid=1 with final s_out from edge k+1. A single-beat vector (in_last on the first beat) is legal.
- OUT hold: s_out, overflow and out_valid stay stable until the handshake. Back-pressure of any length is allowed.
- Arithmetic when the true sum exceeds range:
  - signed: range [-2^(O-1), 2^(O-1)-1].
  - unsigned: range [0, 2^O-1].
  - sat_en=1: clamp to the bound and set overflow[i].
  - sat_en=0: wrap modulo 2^O and set overflow[i].
  - overflow is sticky until the result handshake or reset.
- Once saturated, the accumulator continues from the clamped value.
- Mixing modes within one vector is permitted; each beat uses its own sampled mode.
- s_out register is updated from the accumulators on entering OUT; it reads 0 after reset.

Decomposition:
- Package vector_mac_pe_pkg:
  - state enum {ACCUM, FLUSH, OUT};
  - functions for signed/unsigned range bounds as a function of OUTPUT_PRECISION;
  - saturating/wrapping add helper returning {sum, ovf}.
- Sub-module mac_lane: one lane, containing the product register, extension, accumulator, saturation and sticky overflow. It is instantiated LANES times in a generate loop.
- The top level holds the FSM, handshakes and lane packing.

Test Plan:
1. Defaults, unsigned, sat_en=0, 4 beats with lane i a=i+1, b=2, last on beat 4 -> out_valid one edge after last accept; lanes = 8, 16, 24, 32; overflow=0.
2. signed_mode=1, every lane a=0xFD(-3), b=5, 4 beats -> each lane s_out=0xFFFFFFC4 (-60), overflow=0.
3. OUTPUT_PRECISION=17, signed, sat_en=1, 5 beats a=b=127 (sum 80645) -> s_out=65535 (0x0FFFF), overflow=1. Repeat with sat_en=0 -> 80645 mod 2^17 = 80645, read as signed = -50427; overflow=1.
4. OUTPUT_PRECISION=17, unsigned, 3 beats a=b=255 (195075):
   - sat_en=1 -> 131071, overflow=1;
   - sat_en=0 -> 64003, overflow=1.
5. Hold out_ready=0 for 10 cycles in OUT while driving in_valid=1 -> in_ready=0, s_out stable. Release -> next vector starts from 0, and its single beat a=b=1 yields 1 per lane.
6. Assert reset for 1 cycle in FLUSH after in_last -> no out_valid; out_valid, s_out and overflow read 0; next vector accumulates from 0.

Source files
------------

// File: rtl/vector_mac_pe_pkg.sv
// Shared types and arithmetic helpers for the vector MAC processing element.
package vector_mac_pe_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FLUSH = 2'd1,
    OUT   = 2'd2
  } state_t;

  // Working width for the helpers; accumulator widths up to MAX_W-1 bits are supported.
  localparam int MAX_W = 64;
  // Two guard bits so the true (unbounded) sum of two MAX_W operands never wraps.
  localparam int EXT_W = MAX_W + 2;

  typedef struct packed {
    logic [MAX_W-1:0] sum;
    logic             ovf;
  } add_res_t;

  function automatic logic signed [EXT_W-1:0] smax_f(input int o);
    return $signed((EXT_W'(1) << (o - 1)) - EXT_W'(1));
  endfunction

  function automatic logic signed [EXT_W-1:0] smin_f(input int o);
    return $signed(EXT_W'(0) - (EXT_W'(1) << (o - 1)));
  endfunction

  function automatic logic signed [EXT_W-1:0] umax_f(input int o);
    return $signed((EXT_W'(1) << o) - EXT_W'(1));
  endfunction

  // Adds two operands already extended to MAX_W according to sgn. The result is
  // clamped (sat=1) or wrapped modulo 2^o (sat=0); ovf flags an out-of-range true sum.
  function automatic add_res_t sat_add(input logic signed [MAX_W-1:0] acc,
                                       input logic signed [MAX_W-1:0] addend,
                                       input int o, input logic sgn, input logic sat);
    add_res_t                res;
    logic signed [EXT_W-1:0] t;
    logic signed [EXT_W-1:0] hi;
    logic signed [EXT_W-1:0] lo;
    logic signed [EXT_W-1:0] mask;
    t    = EXT_W'(acc) + EXT_W'(addend);
    hi   = sgn ? smax_f(o) : umax_f(o);
    lo   = sgn ? smin_f(o) : '0;
    mask = umax_f(o);
    res.ovf = (t > hi) || (t < lo);
    if (res.ovf && sat) res.sum = MAX_W'(((t > hi) ? hi : lo) & mask);
    else                res.sum = MAX_W'(t & mask);
    return res;
  endfunction

endpackage

// File: rtl/vector_mac_pe_lane.sv
// One MAC lane: registered product, extension, accumulate with saturate/wrap, sticky overflow.
module mac_lane
  import vector_mac_pe_pkg::*;
#(
  parameter int PRECISION        = 8,
  parameter int OUTPUT_PRECISION = 32
) (
  input  logic                        CLK,
  input  logic                        reset,
  input  logic                        vld_p0,
  input  logic                        vld_p1,
  input  logic                        clr,
  input  logic                        signed_mode,
  input  logic                        sat_en,
  input  logic [PRECISION-1:0]        a,
  input  logic [PRECISION-1:0]        b,
  output logic [OUTPUT_PRECISION-1:0] acc_nxt,
  output logic                        ovf
);

  localparam int PW = 2 * PRECISION;

  logic signed [PW-1:0]               prod_s;
  logic        [PW-1:0]               prod_u;
  logic signed [PW-1:0]               prod_p1;
  logic                               sgn_p1;
  logic                               sat_p1;
  logic signed [MAX_W-1:0]            ext_p1;
  logic signed [MAX_W-1:0]            acc_x;
  logic        [OUTPUT_PRECISION-1:0] acc;
  add_res_t                           r;
  logic                               unused_hi;

  assign prod_s = $signed(a) * $signed(b);
  assign prod_u = PW'(a) * PW'(b);

  // Stage 1: capture the full-width product together with the beat's modes.
  always_ff @(posedge CLK) begin
    if (reset) begin
      prod_p1 <= '0;
      sgn_p1  <= 1'b0;
      sat_p1  <= 1'b0;
    end else if (vld_p0) begin
      prod_p1 <= signed_mode ? prod_s : $signed(prod_u);
      sgn_p1  <= signed_mode;
      sat_p1  <= sat_en;
    end
  end

  // Stage 2: both operands are interpreted in the mode of the beat being added.
  assign ext_p1    = sgn_p1 ? MAX_W'(prod_p1) : MAX_W'($unsigned(prod_p1));
  assign acc_x     = sgn_p1 ? MAX_W'($signed(acc)) : MAX_W'(acc);
  assign r         = sat_add(acc_x, ext_p1, OUTPUT_PRECISION, sgn_p1, sat_p1);
  assign unused_hi = ^r.sum[MAX_W-1:OUTPUT_PRECISION];
  assign acc_nxt   = clr ? '0 : (vld_p1 ? r.sum[OUTPUT_PRECISION-1:0] : acc);

  // Accumulator and sticky overflow; both clear on the result handshake.
  always_ff @(posedge CLK) begin
    if (reset) begin
      acc <= '0;
      ovf <= 1'b0;
    end else begin
      acc <= acc_nxt;
      if (clr)                 ovf <= 1'b0;
      else if (vld_p1 && r.ovf) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/vector_mac_pe.sv
// Multi-lane pipelined MAC PE: vector framing FSM, handshakes and lane packing.
// OUTPUT_PRECISION must lie in [2*PRECISION+1, 63].
module vector_mac_pe
  import vector_mac_pe_pkg::*;
#(
  parameter int PRECISION        = 8,
  parameter int OUTPUT_PRECISION = 32,
  parameter int LANES            = 4
) (
  input  logic                              CLK,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_last,
  input  logic                              signed_mode,
  input  logic                              sat_en,
  input  logic [LANES*PRECISION-1:0]        a_in,
  input  logic [LANES*PRECISION-1:0]        b_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [LANES*OUTPUT_PRECISION-1:0] s_out,
  output logic [LANES-1:0]                  overflow
);

  state_t                              state;
  state_t                              state_nxt;
  logic                                vld_p0;
  logic                                vld_p1;
  logic                                clr;
  logic [LANES*OUTPUT_PRECISION-1:0]   acc_nxt_all;

  assign in_ready  = (state == ACCUM) && !reset;
  assign vld_p0    = in_valid && in_ready;
  assign out_valid = (state == OUT);
  assign clr       = (state == OUT) && out_ready;

  // Next-state logic: the last beat drains through one stage before the result is offered.
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (vld_p0 && in_last) state_nxt = FLUSH;
      FLUSH:   state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // State register and stage-1 valid.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state  <= ACCUM;
      vld_p1 <= 1'b0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= vld_p0;
    end
  end

  genvar i;
  for (i = 0; i < LANES; i++) begin : g_lane
    mac_lane #(
      .PRECISION       (PRECISION),
      .OUTPUT_PRECISION(OUTPUT_PRECISION)
    ) u_lane (
      .CLK        (CLK),
      .reset      (reset),
      .vld_p0     (vld_p0),
      .vld_p1     (vld_p1),
      .clr        (clr),
      .signed_mode(signed_mode),
      .sat_en     (sat_en),
      .a          (a_in[i*PRECISION +: PRECISION]),
      .b          (b_in[i*PRECISION +: PRECISION]),
      .acc_nxt    (acc_nxt_all[i*OUTPUT_PRECISION +: OUTPUT_PRECISION]),
      .ovf        (overflow[i])
    );
  end

  // Result register: loaded with the final accumulators on the edge that enters OUT.
  always_ff @(posedge CLK) begin
    if (reset)               s_out <= '0;
    else if (state == FLUSH) s_out <= acc_nxt_all;
  end

endmodule

// File: tb/tb_vector_mac_pe.sv
// Self-checking bench: two PE instances (32-bit and 17-bit results) share one stimulus stream.
module tb_vector_mac_pe;

  logic         CLK = 1'b0;
  logic         reset, in_valid, in_last, signed_mode, sat_en, out_ready;
  logic [31:0]  a_in, b_in;
  logic         in_ready32, in_ready17, out_valid32, out_valid17;
  logic [127:0] s_out32;
  logic [67:0]  s_out17;
  logic [3:0]   ov32, ov17;

  int total, bad, nb, bubble_pct;
  logic [7:0] ba [64][4];
  logic [7:0] bb [64][4];
  logic       bs [64];
  logic       bt [64];
  logic [127:0] e32;
  logic [67:0]  e17;
  logic [3:0]   eo32, eo17;

  always #5 CLK = ~CLK;

  vector_mac_pe #(.PRECISION(8), .OUTPUT_PRECISION(32), .LANES(4)) dut32 (
    .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_ready(in_ready32), .in_last(in_last),
    .signed_mode(signed_mode), .sat_en(sat_en), .a_in(a_in), .b_in(b_in),
    .out_valid(out_valid32), .out_ready(out_ready), .s_out(s_out32), .overflow(ov32));

  vector_mac_pe #(.PRECISION(8), .OUTPUT_PRECISION(17), .LANES(4)) dut17 (
    .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_ready(in_ready17), .in_last(in_last),
    .signed_mode(signed_mode), .sat_en(sat_en), .a_in(a_in), .b_in(b_in),
    .out_valid(out_valid17), .out_ready(out_ready), .s_out(s_out17), .overflow(ov17));

  // Reference: true integer sum per beat, range-checked in the beat's mode, then clamped or reduced mod 2^o.
  function automatic longint lane_model(input int lane, input int o, output logic ovf);
    longint acc, p, av, t, lo, hi, m;
    acc = 0; ovf = 1'b0; m = longint'(1) << o;
    for (int k = 0; k < nb; k++) begin
      if (bs[k]) p = longint'($signed(ba[k][lane])) * longint'($signed(bb[k][lane]));
      else       p = longint'(ba[k][lane]) * longint'(bb[k][lane]);
      av = (bs[k] && acc >= m / 2) ? acc - m : acc;
      lo = bs[k] ? -(m / 2) : 0;
      hi = bs[k] ? (m / 2) - 1 : m - 1;
      t  = av + p;
      if (t > hi || t < lo) begin
        ovf = 1'b1;
        if (bt[k]) t = (t > hi) ? hi : lo;
      end
      acc = ((t % m) + m) % m;
    end
    return acc;
  endfunction

  task automatic compute_expected();
    logic o;
    for (int l = 0; l < 4; l++) begin
      e32[l*32 +: 32] = 32'(lane_model(l, 32, o)); eo32[l] = o;
      e17[l*17 +: 17] = 17'(lane_model(l, 17, o)); eo17[l] = o;
    end
  endtask

  task automatic fill_const(input int n, input logic [7:0] a, input logic [7:0] b,
                            input logic sgn, input logic sat);
    nb = n;
    for (int k = 0; k < n; k++) begin
      for (int l = 0; l < 4; l++) begin ba[k][l] = a; bb[k][l] = b; end
      bs[k] = sgn; bt[k] = sat;
    end
  endtask

  task automatic fill_random(input int n);
    nb = n;
    for (int k = 0; k < n; k++) begin
      for (int l = 0; l < 4; l++) begin ba[k][l] = 8'($urandom); bb[k][l] = 8'($urandom); end
      bs[k] = 1'($urandom); bt[k] = 1'($urandom);
    end
  endtask

  // Drives the stored beats with random bubbles; returns #1 after the edge that accepts the last beat.
  task automatic send_beats(output bit to);
    int  k, cyc;
    logic rdy;
    k = 0; cyc = 0; to = 1'b0;
    while (k < nb) begin
      @(negedge CLK);
      if (int'($urandom_range(99)) < bubble_pct) begin
        in_valid = 1'b0; a_in = $urandom; b_in = $urandom; in_last = 1'($urandom);
      end else begin
        in_valid = 1'b1; signed_mode = bs[k]; sat_en = bt[k]; in_last = (k == nb - 1);
        for (int l = 0; l < 4; l++) begin a_in[l*8 +: 8] = ba[k][l]; b_in[l*8 +: 8] = bb[k][l]; end
      end
      rdy = in_ready32;
      @(posedge CLK);
      if (in_valid && rdy) k++;
      cyc++;
      if (cyc > 2000) begin to = 1'b1; break; end
    end
    #1; in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge CLK); #1; lat++;
    end while (!out_valid32 && lat < 20);
  endtask

  task automatic handshake();
    @(negedge CLK); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge CLK); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1;
    @(negedge CLK);
    total++; if ({in_ready32, in_ready17} !== 2'b00) begin bad++; $display("FAIL reset_in_ready got=%b exp=00", {in_ready32, in_ready17}); end
    @(negedge CLK); reset = 1'b0; in_valid = 1'b0;
    #1;
    total++; if ({out_valid32, out_valid17, ov32, ov17, s_out32, s_out17} !== '0) begin bad++;
      $display("FAIL reset_outputs got ov=%b/%b s=%h/%h vld=%b%b exp all zero", ov32, ov17, s_out32, s_out17, out_valid32, out_valid17); end
    total++; if (in_ready32 !== 1'b1) begin bad++; $display("FAIL reset_ready_after got=%b exp=1", in_ready32); end
  endtask

  task automatic test_unsigned();
    bit to; int lat;
    fill_const(4, 8'd0, 8'd2, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) for (int l = 0; l < 4; l++) ba[k][l] = 8'(l + 1);
    bubble_pct = 0; compute_expected();
    send_beats(to); wait_out(lat);
    total++; if (to || lat !== 1) begin bad++; $display("FAIL unsigned_latency got=%0d timeout=%0b exp=1", lat, to); end
    total++; if ({s_out32, ov32, s_out17, ov17} !== {e32, eo32, e17, eo17}) begin bad++;
      $display("FAIL unsigned_result got=%h %b %h %b exp=%h %b %h %b", s_out32, ov32, s_out17, ov17, e32, eo32, e17, eo17); end
    total++; if ({s_out32, ov32} !== {32'd32, 32'd24, 32'd16, 32'd8, 4'b0}) begin bad++;
      $display("FAIL unsigned_lanes got=%h ov=%b exp=lanes 8,16,24,32 ov=0", s_out32, ov32); end
    handshake();
  endtask

  task automatic test_signed();
    bit to; int lat;
    fill_const(4, 8'hFD, 8'd5, 1'b1, 1'b0);
    bubble_pct = 20; compute_expected();
    send_beats(to); wait_out(lat);
    total++; if (to || lat !== 1) begin bad++; $display("FAIL signed_latency got=%0d timeout=%0b exp=1", lat, to); end
    total++; if ({s_out32, ov32, s_out17, ov17} !== {e32, eo32, e17, eo17}) begin bad++;
      $display("FAIL signed_result got=%h %b %h %b exp=%h %b %h %b", s_out32, ov32, s_out17, ov17, e32, eo32, e17, eo17); end
    total++; if ({s_out32, ov32} !== {{4{32'hFFFFFFC4}}, 4'b0}) begin bad++;
      $display("FAIL signed_lanes got=%h ov=%b exp=4x FFFFFFC4 ov=0", s_out32, ov32); end
    handshake();
  endtask

  task automatic test_sat17();
    bit to; int lat;
    for (int sat = 1; sat >= 0; sat--) begin
      fill_const(5, 8'd127, 8'd127, 1'b1, 1'(sat));
      bubble_pct = 30; compute_expected();
      send_beats(to); wait_out(lat);
      total++; if (to || {s_out32, ov32, s_out17, ov17} !== {e32, eo32, e17, eo17}) begin bad++;
        $display("FAIL sat17_result sat=%0d got=%h %b %h %b exp=%h %b %h %b", sat, s_out32, ov32, s_out17, ov17, e32, eo32, e17, eo17); end
      total++; if ({s_out17, ov17} !== {{4{sat ? 17'h0FFFF : 17'h13B05}}, 4'hF}) begin bad++;
        $display("FAIL sat17_lanes sat=%0d got=%h ov=%b", sat, s_out17, ov17); end
      handshake();
    end
  endtask

  task automatic test_unsigned17();
    bit to; int lat;
    for (int sat = 1; sat >= 0; sat--) begin
      fill_const(3, 8'd255, 8'd255, 1'b0, 1'(sat));
      bubble_pct = 30; compute_expected();
      send_beats(to); wait_out(lat);
      total++; if (to || {s_out32, ov32, s_out17, ov17} !== {e32, eo32, e17, eo17}) begin bad++;
        $display("FAIL uns17_result sat=%0d got=%h %b %h %b exp=%h %b %h %b", sat, s_out32, ov32, s_out17, ov17, e32, eo32, e17, eo17); end
      total++; if ({s_out17, ov17} !== {{4{sat ? 17'd131071 : 17'd64003}}, 4'hF}) begin bad++;
        $display("FAIL uns17_lanes sat=%0d got=%h ov=%b", sat, s_out17, ov17); end
      handshake();
    end
  endtask

  task automatic test_backpressure();
    bit to; int lat;
    fill_random(3); bubble_pct = 0; compute_expected();
    send_beats(to); wait_out(lat);
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      in_valid = 1'b1; in_last = 1'($urandom); a_in = $urandom; b_in = $urandom;
      #1;
      total++; if ({in_ready32, in_ready17, out_valid32, out_valid17} !== 4'b0011) begin bad++;
        $display("FAIL hold_handshake cyc=%0d got rdy=%b%b vld=%b%b exp rdy=00 vld=11", c, in_ready32, in_ready17, out_valid32, out_valid17); end
      total++; if ({s_out32, ov32, s_out17, ov17} !== {e32, eo32, e17, eo17}) begin bad++;
        $display("FAIL hold_stable cyc=%0d got=%h %b %h %b exp=%h %b %h %b", c, s_out32, ov32, s_out17, ov17, e32, eo32, e17, eo17); end
    end
    handshake();
    fill_const(1, 8'd1, 8'd1, 1'b0, 1'b0); compute_expected();
    send_beats(to); wait_out(lat);
    total++; if (to || lat !== 1 || {s_out32, ov32, s_out17, ov17} !== {{4{32'd1}}, 4'b0, {4{17'd1}}, 4'b0}) begin bad++;
      $display("FAIL after_hold got=%h %b %h %b lat=%0d exp=all lanes 1 ov=0 lat=1", s_out32, ov32, s_out17, ov17, lat); end
    handshake();
  endtask

  task automatic test_reset_flush();
    bit to; int lat;
    fill_const(4, 8'd255, 8'd255, 1'b0, 1'b1); bubble_pct = 0;
    send_beats(to);
    total++; if (ov17 !== 4'hF) begin bad++; $display("FAIL pre_reset_ovf got=%b exp=1111", ov17); end
    reset = 1'b1;
    @(posedge CLK); #1; reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      total++; if ({out_valid32, out_valid17, ov32, ov17, s_out32, s_out17} !== '0) begin bad++;
        $display("FAIL flush_reset cyc=%0d got vld=%b%b ov=%b/%b s=%h/%h exp all zero", c, out_valid32, out_valid17, ov32, ov17, s_out32, s_out17); end
      @(posedge CLK); #1;
    end
    fill_const(1, 8'd1, 8'd1, 1'b0, 1'b0);
    send_beats(to); wait_out(lat);
    total++; if (to || lat !== 1 || {s_out32, ov32, s_out17, ov17} !== {{4{32'd1}}, 4'b0, {4{17'd1}}, 4'b0}) begin bad++;
      $display("FAIL after_reset got=%h %b %h %b lat=%0d exp=all lanes 1 ov=0 lat=1", s_out32, ov32, s_out17, ov17, lat); end
    handshake();
  endtask

  task automatic test_random();
    bit to; int lat;
    for (int v = 0; v < 12; v++) begin
      fill_random(int'($urandom_range(1, 10))); bubble_pct = 25; compute_expected();
      send_beats(to); wait_out(lat);
      repeat (int'($urandom_range(0, 3))) @(posedge CLK);
      #1;
      total++; if (to || lat !== 1) begin bad++; $display("FAIL rand_latency v=%0d got=%0d timeout=%0b exp=1", v, lat, to); end
      total++; if ({s_out32, ov32, s_out17, ov17} !== {e32, eo32, e17, eo17}) begin bad++;
        $display("FAIL rand_result v=%0d got=%h %b %h %b exp=%h %b %h %b", v, s_out32, ov32, s_out17, ov17, e32, eo32, e17, eo17); end
      handshake();
      total++; if ({out_valid32, out_valid17, ov32, ov17} !== 10'b0) begin bad++;
        $display("FAIL rand_clear v=%0d got vld=%b%b ov=%b/%b exp zero", v, out_valid32, out_valid17, ov32, ov17); end
    end
  endtask

  initial begin
    total = 0; bad = 0; bubble_pct = 0; nb = 0;
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; signed_mode = 1'b0; sat_en = 1'b0;
    out_ready = 1'b0; a_in = '0; b_in = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_sat17();
    test_unsigned17();
    test_backpressure();
    test_reset_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
